page_port_adapter: RTL and testbench
====================================

# page_port_adapter

Parametrised, buffered bridge between the user-side ports of `leaf_interface` and an HLS `user_kernel` inside a page. It is the multi-port generalisation of the direct wire-up between the two. It carries NUM_IN_PORTS input channels and NUM_OUT_PORTS output channels. Each channel has its own FIFO, so BFT-side and kernel-side stalls are decoupled, and the block reports occupancy and transfer counts for page debug.

## Interface
- PAYLOAD_BITS, 32, word width per channel
- NUM_IN_PORTS, 2, interface→kernel channels (1..8)
- NUM_OUT_PORTS, 2, kernel→interface channels (1..8)
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2
- AW, log2(FIFO_DEPTH), derived, not overridden
---
- clk  in  1  page clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; 0 = reset
- flush  in  1  synchronous clear of all FIFOs and counters, active-high
- dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  words from leaf_interface; channel i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_interface2user  in  NUM_IN_PORTS  per-channel valid
- ack_user2interface  out  NUM_IN_PORTS  per-channel accept
- Input_V_V  out  NUM_IN_PORTS*PAYLOAD_BITS  words to kernel
- Input_V_V_ap_vld  out  NUM_IN_PORTS  to kernel
- Input_V_V_ap_ack  in  NUM_IN_PORTS  from kernel
- Output_V_V  in  NUM_OUT_PORTS*PAYLOAD_BITS  words from kernel
- Output_V_V_ap_vld  in  NUM_OUT_PORTS  from kernel
- Output_V_V_ap_ack  out  NUM_OUT_PORTS  to kernel
- din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  words to leaf_interface
- vld_user2interface  out  NUM_OUT_PORTS  to leaf_interface
- ack_interface2user  in  NUM_OUT_PORTS  from leaf_interface
- in_occ  out  NUM_IN_PORTS*(AW+1)  per-channel input FIFO occupancy
- out_occ  out  NUM_OUT_PORTS*(AW+1)  per-channel output FIFO occupancy
- in_xfer_cnt  out  32  total words delivered to the kernel, all channels
- out_xfer_cnt  out  32  total words delivered to leaf_interface, all channels

## Operation
- Handshake on every port pair: a word transfers in a cycle where vld=1 and ack=1. A producer holds its data stable while vld=1 and ack=0.
- Each channel has an independent FIFO of FIFO_DEPTH entries. It uses AW-bit read/write pointers that wrap modulo FIFO_DEPTH and an (AW+1)-bit occupancy count.
- Upstream side of each FIFO: ack = (occ != FIFO_DEPTH). Push when vld & ack.
- Downstream side of each FIFO: vld = (occ != 0), data = entry at the read pointer, registered from FIFO storage. Pop when vld & ack.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. This is legal at any occupancy 1..FIFO_DEPTH-1.
- Full FIFO: ack=0, so no push occurs even if a pop happens in the same cycle. There is no combinational ready pass-through.
- Empty FIFO: vld=0. A word pushed in cycle N is visible downstream in cycle N+1. There is no combinational bypass.
- Channels never interact. A stall on one channel does not affect any other.
- in_xfer_cnt adds popcount(Input_V_V_ap_vld & Input_V_V_ap_ack) each cycle. out_xfer_cnt adds popcount(vld_user2interface & ack_interface2user) each cycle. Both wrap modulo 2^32.
- flush=1 behaves as a synchronous reset, with the same values as asynchronous reset. No transfer completes in a flush cycle. While flush=1, every ack and vld output is forced to 0.
- reset=0, asynchronous and at any point including mid-transfer, has the following effects:
  - all pointers, occupancies and counters go to 0;
  - every vld and ack output goes to 0;
  - in-flight words are discarded;
  - data outputs go to 0.

## Timing
- Minimum latency is 1 cycle from an upstream handshake to downstream vld.
- Throughput is 1 word/cycle/channel sustained when both sides are always ready. FIFO_DEPTH ≥ 2 is required for this.
- All outputs are registered or derived from registered occupancy only. There are no combinational input-to-output paths.
- Occupancy outputs reflect the state after the previous edge.
- Reset values: ack_user2interface=0, Output_V_V_ap_ack=0, Input_V_V_ap_vld=0, vld_user2interface=0, all data=0, in_occ=out_occ=0, in_xfer_cnt=out_xfer_cnt=0.
- Acks rise on the first clk edge after reset deasserts.

## Test plan
- Reset release with FIFO_DEPTH=4: after the first edge, all upstream acks=1, all downstream vlds=0, occ=0, counters=0.
- Streaming: drive words 1..100 on input channel 0 with the kernel ack held at 1. Required: Input_V_V ch0 receives 1..100 in order at 1 word/cycle after 1 cycle of latency, and in_xfer_cnt=100.
- Backpressure: kernel ack=0 on input ch1 while 6 words are offered. Required: the first 4 are accepted, in_occ ch1=4, ack_user2interface[1]=0. When ack is released, the 4 words drain in order and the remaining 2 then pass. Ch0 traffic is unaffected throughout.
- Simultaneous push/pop at occ=2 on output ch0 for 10 cycles: occupancy stays 2 and ordering is preserved.
- Flush with output ch1 at occ=3: the next cycle shows occ=0, vld=0, out_xfer_cnt=0, and ack is 0 during the flush cycle.
- Asynchronous reset asserted mid-cycle during full-rate traffic: all outputs go to their reset values immediately, without waiting for a clock edge. After release, only new words are delivered.

Source files
------------

// File: rtl/page_port_adapter.sv
// Buffered multi-channel bridge between leaf_interface user ports and an HLS kernel.
// Every channel owns a small FIFO; occupancy and transfer totals are exported for page debug.

module page_port_adapter_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] up_data,
    input  logic         up_vld,
    output logic         up_ack,
    output logic [W-1:0] dn_data,
    output logic         dn_vld,
    input  logic         dn_ack,
    output logic [AW:0]  occ
);
    localparam logic [AW:0]   FULL_OCC  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   EMPTY_OCC = (AW+1)'(1'b0);
    localparam logic [AW:0]   ONE_OCC   = (AW+1)'(1'b1);
    localparam logic [AW-1:0] ONE_PTR   = AW'(1'b1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   occ_r;
    logic          ready_r;
    logic          push_s;
    logic          pop_s;
    logic [AW:0]   occ_next_s;

    // Handshake outputs come from registered state only; flush masks both sides.
    always_comb begin
        up_ack = 1'b0;
        dn_vld = 1'b0;
        if (flush) begin
            up_ack = 1'b0;
            dn_vld = 1'b0;
        end else begin
            up_ack = ready_r && (occ_r != FULL_OCC);
            dn_vld = (occ_r != EMPTY_OCC);
        end
    end

    // Head-of-queue word, held at zero while the FIFO is empty.
    always_comb begin
        dn_data = {W{1'b0}};
        if (occ_r != EMPTY_OCC) begin
            dn_data = mem_r[rd_ptr_r];
        end else begin
            dn_data = {W{1'b0}};
        end
    end

    assign push_s = up_vld & up_ack;
    assign pop_s  = dn_vld & dn_ack;
    assign occ    = occ_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        occ_next_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = occ_r + ONE_OCC;
            2'b01:   occ_next_s = occ_r - ONE_OCC;
            default: occ_next_s = occ_r;
        endcase
    end

    // Pointer, occupancy and ready state; flush clears exactly like reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= EMPTY_OCC;
            ready_r  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= EMPTY_OCC;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            occ_r   <= occ_next_s;
            ready_r <= 1'b1;
        end
    end

    // Storage needs no reset: it is only observed through the occupancy-gated head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= up_data;
        end
    end
endmodule

module page_port_adapter #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 2,
    parameter int FIFO_DEPTH    = 4,
    localparam int AW           = $clog2(FIFO_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  Input_V_V,
    output logic [NUM_IN_PORTS-1:0]               Input_V_V_ap_vld,
    input  logic [NUM_IN_PORTS-1:0]               Input_V_V_ap_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] Output_V_V,
    input  logic [NUM_OUT_PORTS-1:0]              Output_V_V_ap_vld,
    output logic [NUM_OUT_PORTS-1:0]              Output_V_V_ap_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    output logic [NUM_IN_PORTS*(AW+1)-1:0]        in_occ,
    output logic [NUM_OUT_PORTS*(AW+1)-1:0]       out_occ,
    output logic [31:0]                           in_xfer_cnt,
    output logic [31:0]                           out_xfer_cnt
);
    logic [NUM_IN_PORTS-1:0]  in_fire_s;
    logic [NUM_OUT_PORTS-1:0] out_fire_s;
    logic [7:0]               in_fire8_s;
    logic [7:0]               out_fire8_s;
    logic [31:0]              in_xfer_cnt_r;
    logic [31:0]              out_xfer_cnt_r;

    function automatic logic [31:0] popcount8(input logic [7:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        page_port_adapter_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .up_data (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .up_vld  (vld_interface2user[i]),
            .up_ack  (ack_user2interface[i]),
            .dn_data (Input_V_V[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .dn_vld  (Input_V_V_ap_vld[i]),
            .dn_ack  (Input_V_V_ap_ack[i]),
            .occ     (in_occ[i*(AW+1) +: (AW+1)])
        );
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        page_port_adapter_fifo #(.W(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .up_data (Output_V_V[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .up_vld  (Output_V_V_ap_vld[j]),
            .up_ack  (Output_V_V_ap_ack[j]),
            .dn_data (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .dn_vld  (vld_user2interface[j]),
            .dn_ack  (ack_interface2user[j]),
            .occ     (out_occ[j*(AW+1) +: (AW+1)])
        );
    end

    assign in_fire_s   = Input_V_V_ap_vld & Input_V_V_ap_ack;
    assign out_fire_s  = vld_user2interface & ack_interface2user;
    assign in_fire8_s  = 8'(in_fire_s);
    assign out_fire8_s = 8'(out_fire_s);

    // Delivered-word totals, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_xfer_cnt_r  <= 32'd0;
            out_xfer_cnt_r <= 32'd0;
        end else if (flush) begin
            in_xfer_cnt_r  <= 32'd0;
            out_xfer_cnt_r <= 32'd0;
        end else begin
            in_xfer_cnt_r  <= in_xfer_cnt_r + popcount8(in_fire8_s);
            out_xfer_cnt_r <= out_xfer_cnt_r + popcount8(out_fire8_s);
        end
    end

    assign in_xfer_cnt  = in_xfer_cnt_r;
    assign out_xfer_cnt = out_xfer_cnt_r;
endmodule

// File: tb/tb_page_port_adapter.sv
// Directed bench for page_port_adapter: queue-based channel model checked every cycle,
// plus literal expectations for the reset, streaming, backpressure, flush and async-reset cases.

module tb_page_port_adapter;
    localparam int PB = 32;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int D  = 4;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [NI*PB-1:0] dout_leaf_interface2user = '0;
    logic [NI-1:0]    vld_interface2user = '0;
    logic [NI-1:0]    ack_user2interface;
    logic [NI*PB-1:0] Input_V_V;
    logic [NI-1:0]    Input_V_V_ap_vld;
    logic [NI-1:0]    Input_V_V_ap_ack = '0;
    logic [NO*PB-1:0] Output_V_V = '0;
    logic [NO-1:0]    Output_V_V_ap_vld = '0;
    logic [NO-1:0]    Output_V_V_ap_ack;
    logic [NO*PB-1:0] din_leaf_user2interface;
    logic [NO-1:0]    vld_user2interface;
    logic [NO-1:0]    ack_interface2user = '0;
    logic [NI*OW-1:0] in_occ;
    logic [NO*OW-1:0] out_occ;
    logic [31:0]      in_xfer_cnt;
    logic [31:0]      out_xfer_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // channel model: word queues, ready-after-reset flag and delivered totals
    logic [31:0] mq_in  [NI][$];
    logic [31:0] mq_out [NO][$];
    bit          m_ready;
    logic [31:0] m_in_cnt, m_out_cnt;
    bit          fired_in [NI];
    bit          fired_out [NO];
    int          cyc = 0;

    logic [31:0] src_in  [NI][$];
    logic [31:0] src_out [NO][$];
    logic [31:0] rx_in   [NI][$];
    logic [31:0] rx_out  [NO][$];
    int          rx_in_cyc [$];
    int          up_first = -1;

    page_port_adapter #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dout_leaf_interface2user(dout_leaf_interface2user),
        .vld_interface2user(vld_interface2user),
        .ack_user2interface(ack_user2interface),
        .Input_V_V(Input_V_V), .Input_V_V_ap_vld(Input_V_V_ap_vld), .Input_V_V_ap_ack(Input_V_V_ap_ack),
        .Output_V_V(Output_V_V), .Output_V_V_ap_vld(Output_V_V_ap_vld), .Output_V_V_ap_ack(Output_V_V_ap_ack),
        .din_leaf_user2interface(din_leaf_user2interface),
        .vld_user2interface(vld_user2interface),
        .ack_interface2user(ack_interface2user),
        .in_occ(in_occ), .out_occ(out_occ),
        .in_xfer_cnt(in_xfer_cnt), .out_xfer_cnt(out_xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NI; c++) begin mq_in[c].delete(); fired_in[c] = 1'b0; end
        for (int c = 0; c < NO; c++) begin mq_out[c].delete(); fired_out[c] = 1'b0; end
        m_ready = 1'b0;
        m_in_cnt = 32'd0;
        m_out_cnt = 32'd0;
    endtask

    task automatic model_advance();
        bit up, dn;
        for (int c = 0; c < NI; c++) begin
            up = vld_interface2user[c] && m_ready && (mq_in[c].size() < D);
            dn = (mq_in[c].size() != 0) && Input_V_V_ap_ack[c];
            if (dn) begin void'(mq_in[c].pop_front()); m_in_cnt++; end
            if (up) mq_in[c].push_back(dout_leaf_interface2user[c*PB +: PB]);
            fired_in[c] = up;
        end
        for (int c = 0; c < NO; c++) begin
            up = Output_V_V_ap_vld[c] && m_ready && (mq_out[c].size() < D);
            dn = (mq_out[c].size() != 0) && ack_interface2user[c];
            if (dn) begin void'(mq_out[c].pop_front()); m_out_cnt++; end
            if (up) mq_out[c].push_back(Output_V_V[c*PB +: PB]);
            fired_out[c] = up;
        end
        m_ready = 1'b1;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else begin
                cyc++;
                if (flush) model_clear();
                else model_advance();
            end
        end
    end

    task automatic compare_all();
        logic [NI-1:0] e_ack_i, e_vld_i;
        logic [NO-1:0] e_ack_o, e_vld_o;
        logic [NI*PB-1:0] e_dat_i;
        logic [NO*PB-1:0] e_dat_o;
        logic [NI*OW-1:0] e_occ_i;
        logic [NO*OW-1:0] e_occ_o;
        for (int c = 0; c < NI; c++) begin
            e_ack_i[c] = !flush && m_ready && (mq_in[c].size() < D);
            e_vld_i[c] = !flush && (mq_in[c].size() != 0);
            e_dat_i[c*PB +: PB] = (mq_in[c].size() != 0) ? mq_in[c][0] : 32'h0;
            e_occ_i[c*OW +: OW] = OW'(mq_in[c].size());
        end
        for (int c = 0; c < NO; c++) begin
            e_ack_o[c] = !flush && m_ready && (mq_out[c].size() < D);
            e_vld_o[c] = !flush && (mq_out[c].size() != 0);
            e_dat_o[c*PB +: PB] = (mq_out[c].size() != 0) ? mq_out[c][0] : 32'h0;
            e_occ_o[c*OW +: OW] = OW'(mq_out[c].size());
        end
        check("ack_user2interface", ack_user2interface, e_ack_i);
        check("Input_V_V_ap_vld", Input_V_V_ap_vld, e_vld_i);
        check("Input_V_V", Input_V_V, e_dat_i);
        check("in_occ", in_occ, e_occ_i);
        check("Output_V_V_ap_ack", Output_V_V_ap_ack, e_ack_o);
        check("vld_user2interface", vld_user2interface, e_vld_o);
        check("din_leaf_user2interface", din_leaf_user2interface, e_dat_o);
        check("out_occ", out_occ, e_occ_o);
        check("in_xfer_cnt", in_xfer_cnt, m_in_cnt);
        check("out_xfer_cnt", out_xfer_cnt, m_out_cnt);
    endtask

    // per-cycle compare plus a monitor of completed downstream handshakes
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                compare_all();
                if (vld_interface2user[0] && ack_user2interface[0] && up_first < 0) up_first = cyc;
                for (int c = 0; c < NI; c++) begin
                    if (Input_V_V_ap_vld[c] && Input_V_V_ap_ack[c]) begin
                        rx_in[c].push_back(Input_V_V[c*PB +: PB]);
                        if (c == 0) rx_in_cyc.push_back(cyc);
                    end
                end
                for (int c = 0; c < NO; c++) begin
                    if (vld_user2interface[c] && ack_interface2user[c])
                        rx_out[c].push_back(din_leaf_user2interface[c*PB +: PB]);
                end
            end
        end
    end

    task automatic present();
        for (int c = 0; c < NI; c++) begin
            vld_interface2user[c] = (src_in[c].size() > 0);
            dout_leaf_interface2user[c*PB +: PB] = (src_in[c].size() > 0) ? src_in[c][0] : 32'h0;
        end
        for (int c = 0; c < NO; c++) begin
            Output_V_V_ap_vld[c] = (src_out[c].size() > 0);
            Output_V_V[c*PB +: PB] = (src_out[c].size() > 0) ? src_out[c][0] : 32'h0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < NI; c++) if (fired_in[c] && src_in[c].size() > 0) void'(src_in[c].pop_front());
        for (int c = 0; c < NO; c++) if (fired_out[c] && src_out[c].size() > 0) void'(src_out[c].pop_front());
        present();
    endtask

    task automatic wait_rx(input bit is_out, input int c, input int n, input int budget, input string name);
        int k = 0;
        int sz;
        sz = is_out ? rx_out[c].size() : rx_in[c].size();
        while (sz < n && k < budget) begin
            tick();
            k++;
            sz = is_out ? rx_out[c].size() : rx_in[c].size();
        end
        check(name, sz, n);
    endtask

    task automatic check_seq(input bit is_out, input int c, input int n, input logic [31:0] base, input string name);
        for (int i = 0; i < n; i++) begin
            if (is_out) begin
                if (i < rx_out[c].size()) check(name, rx_out[c][i], base + i);
            end else begin
                if (i < rx_in[c].size()) check(name, rx_in[c][i], base + i);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack_in"}, ack_user2interface, 2'b00);
        check({name, "_ack_out"}, Output_V_V_ap_ack, 2'b00);
        check({name, "_vld_in"}, Input_V_V_ap_vld, 2'b00);
        check({name, "_vld_out"}, vld_user2interface, 2'b00);
        check({name, "_dat_in"}, Input_V_V, 64'h0);
        check({name, "_dat_out"}, din_leaf_user2interface, 64'h0);
        check({name, "_occ"}, {in_occ, out_occ}, 12'h000);
        check({name, "_cnt"}, {in_xfer_cnt, out_xfer_cnt}, 64'h0);
    endtask

    initial begin
        // reset state and first edge after release
        #2;
        check_all_zero("rst");
        #10;
        reset = 1'b1;
        tick();
        check("rel_ack_in", ack_user2interface, 2'b11);
        check("rel_ack_out", Output_V_V_ap_ack, 2'b11);
        check("rel_vld", {Input_V_V_ap_vld, vld_user2interface}, 4'h0);
        check("rel_occ", {in_occ, out_occ}, 12'h000);

        // streaming 1..100 on input channel 0
        Input_V_V_ap_ack = 2'b11;
        ack_interface2user = 2'b11;
        up_first = -1;
        rx_in_cyc.delete();
        for (int i = 1; i <= 100; i++) src_in[0].push_back(32'(i));
        present();
        wait_rx(1'b0, 0, 100, 200, "stream_wait");
        check_seq(1'b0, 0, 100, 32'd1, "stream_word");
        check("stream_cnt", in_xfer_cnt, 32'd100);
        if (rx_in_cyc.size() == 100) begin
            check("stream_latency", rx_in_cyc[0], up_first + 1);
            check("stream_rate", rx_in_cyc[99] - rx_in_cyc[0], 99);
        end

        // backpressure on input channel 1 with channel 0 streaming alongside
        rx_in[0].delete();
        rx_in[1].delete();
        Input_V_V_ap_ack = 2'b01;
        for (int i = 0; i < 6; i++) src_in[1].push_back(32'h100 + 32'(i));
        for (int i = 0; i < 10; i++) src_in[0].push_back(32'h200 + 32'(i));
        present();
        repeat (12) tick();
        check("bp_occ1", in_occ[OW +: OW], 3'd4);
        check("bp_ack1", ack_user2interface[1], 1'b0);
        check("bp_rx1_none", rx_in[1].size(), 0);
        check("bp_ch0_count", rx_in[0].size(), 10);
        check_seq(1'b0, 0, 10, 32'h200, "bp_ch0_word");
        Input_V_V_ap_ack = 2'b11;
        wait_rx(1'b0, 1, 6, 30, "bp_drain_wait");
        check_seq(1'b0, 1, 6, 32'h100, "bp_ch1_word");
        check("bp_cnt", in_xfer_cnt, 32'd116);

        // simultaneous push and pop at occupancy 2 on output channel 0
        ack_interface2user = 2'b10;
        src_out[0].push_back(32'h300);
        src_out[0].push_back(32'h301);
        present();
        repeat (3) tick();
        check("sim_occ_start", out_occ[0 +: OW], 3'd2);
        for (int i = 2; i < 12; i++) src_out[0].push_back(32'h300 + 32'(i));
        ack_interface2user = 2'b11;
        present();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("sim_occ", out_occ[0 +: OW], 3'd2);
        end
        wait_rx(1'b1, 0, 12, 20, "sim_drain_wait");
        check_seq(1'b1, 0, 12, 32'h300, "sim_word");
        check("sim_cnt", out_xfer_cnt, 32'd12);

        // flush with output channel 1 holding three words
        ack_interface2user = 2'b01;
        for (int i = 0; i < 3; i++) src_out[1].push_back(32'h400 + 32'(i));
        present();
        repeat (4) tick();
        check("fl_occ_before", out_occ[OW +: OW], 3'd3);
        flush = 1'b1;
        #1;
        check("fl_ack_in", ack_user2interface, 2'b00);
        check("fl_ack_out", Output_V_V_ap_ack, 2'b00);
        check("fl_vld", {Input_V_V_ap_vld, vld_user2interface}, 4'h0);
        tick();
        flush = 1'b0;
        check("fl_occ_after", out_occ[OW +: OW], 3'd0);
        check("fl_vld_after", vld_user2interface, 2'b00);
        check("fl_out_cnt", out_xfer_cnt, 32'd0);
        check("fl_in_cnt", in_xfer_cnt, 32'd0);
        ack_interface2user = 2'b11;
        repeat (2) tick();

        // asynchronous reset in the middle of full-rate traffic
        for (int c = 0; c < NI; c++) rx_in[c].delete();
        for (int c = 0; c < NO; c++) rx_out[c].delete();
        for (int i = 0; i < 20; i++) src_in[0].push_back(32'h500 + 32'(i));
        for (int i = 0; i < 20; i++) src_out[1].push_back(32'h600 + 32'(i));
        present();
        repeat (6) tick();
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("arst");
        for (int c = 0; c < NI; c++) begin src_in[c].delete(); rx_in[c].delete(); end
        for (int c = 0; c < NO; c++) begin src_out[c].delete(); rx_out[c].delete(); end
        present();
        repeat (2) tick();
        #3;
        reset = 1'b1;
        tick();
        check("arst_rel_ack", {ack_user2interface, Output_V_V_ap_ack}, 4'hF);
        for (int i = 0; i < 5; i++) src_in[0].push_back(32'h700 + 32'(i));
        present();
        wait_rx(1'b0, 0, 5, 20, "arst_new_wait");
        check_seq(1'b0, 0, 5, 32'h700, "arst_new_word");
        check("arst_no_old_out", rx_out[1].size(), 0);
        check("arst_cnt", in_xfer_cnt, 32'd5);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
